// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported unified memory between the fetch and data ports.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin tie-break instead of data-port priority.
module unified_mem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mreq_t;

    state_t        r_state, w_next;
    logic [3:0]    r_cnt;
    logic          r_owner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_d_rdata;
    logic          w_grant;
    logic          w_gnt_port;
    mreq_t         w_req;

    assign w_grant = (r_state == S_IDLE) && (if_req || d_req);

`ifdef ARB_ROUND_ROBIN_EN
    // Pointer starts on the data port so the first tie goes to fetch.
    logic r_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_last <= 1'b1;
        else if (w_grant)
            r_last <= w_gnt_port;
    end

    assign w_gnt_port = (if_req && d_req) ? ~r_last : d_req;
`else
    assign w_gnt_port = d_req;
`endif

    always_comb begin
        w_req.we    = 1'b0;
        w_req.addr  = if_addr;
        w_req.wdata = '0;
        if (w_gnt_port) begin
            w_req.we    = d_we;
            w_req.addr  = d_addr;
            w_req.wdata = d_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (if_req || d_req) w_next = S_ACCESS;
            S_ACCESS: if (r_cnt == 4'd0)   w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Request fields are latched at grant so requester changes during ACCESS are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_owner    <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else if (w_grant) begin
            r_cnt   <= 4'(MEM_LATENCY - 1);
            r_owner <= w_gnt_port;
            r_we    <= w_req.we;
            r_addr  <= w_req.addr;
            r_wdata <= w_req.wdata;
        end else if (r_state == S_ACCESS) begin
            if (r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            else if (!r_we) begin
                if (r_owner)
                    r_d_rdata <= mem_rdata;
                else
                    r_if_rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        mem_en = 1'b0;
        mem_we = 1'b0;
        busy   = 1'b0;
        if_ack = 1'b0;
        d_ack  = 1'b0;
        case (r_state)
            S_ACCESS: begin
                mem_en = 1'b1;
                mem_we = r_we;
                busy   = 1'b1;
            end
            S_RESP: begin
                busy   = 1'b1;
                if_ack = ~r_owner;
                d_ack  = r_owner;
            end
            default: ;
        endcase
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign owner     = r_owner;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed cases plus random traffic against a transaction-level model.
// Three instances share stimulus: latency 2 (fully modelled), 1 and 15 (checked on a single load).
module tb_unified_mem_arbiter;
    localparam int ML = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [2:0]  if_ack, d_ack, mem_en, mem_we, busy, owner;
    logic [31:0] if_rdata[3], d_rdata[3], mem_addr[3], mem_wdata[3], mem_rdata[3];

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Memory drives valid data only in the last enabled cycle of an access, garbage before.
    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        int run;

        always @(posedge clk or posedge reset) begin
            if (reset) run <= 0;
            else       run <= mem_en[g] ? run + 1 : 0;
        end

        assign mem_rdata[g] = (mem_en[g] && run == L - 1) ? memf(mem_addr[g]) : ~memf(mem_addr[g]);

        unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LATENCY(L)) u_dut (
            .clk(clk), .reset(reset),
            .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack[g]), .if_rdata(if_rdata[g]),
            .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_ack(d_ack[g]), .d_rdata(d_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
            .busy(busy[g]), .owner(owner[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model of the latency-2 instance.
    int          e = 0;
    int          idle_at;
    bit          act, g_port, g_we, x_owner, rr_last, x_if_ack, x_d_ack;
    int          g_edge;
    logic [31:0] g_addr, g_wdata, x_maddr, x_mwdata, x_if_rd, x_d_rd;

    task automatic model_reset();
        act = 0; idle_at = e + 1; x_owner = 0; rr_last = 1;
        x_maddr = '0; x_mwdata = '0; x_if_rd = '0; x_d_rd = '0;
        x_if_ack = 0; x_d_ack = 0;
    endtask

    task automatic model_edge();
        bit p;
        if (e >= idle_at) begin
            if (if_req || d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                p = (if_req && d_req) ? !rr_last : d_req;
`else
                p = d_req;
`endif
                act = 1; g_edge = e; g_port = p;
                g_we    = p ? d_we : 1'b0;
                g_addr  = p ? d_addr : if_addr;
                g_wdata = p ? d_wdata : 32'h0;
                rr_last = p; x_owner = p; x_maddr = g_addr; x_mwdata = g_wdata;
                idle_at = e + ML + 2;
            end else begin
                idle_at = e + 1;
            end
        end
    endtask

    task automatic check_cycle();
        bit in_acc, in_resp;
        in_acc  = act && e >= g_edge && e < g_edge + ML;
        in_resp = act && e == g_edge + ML;
        x_if_ack = in_resp && !g_port;
        x_d_ack  = in_resp && g_port;
        if (in_resp && !g_we) begin
            if (g_port) x_d_rd  = memf(g_addr);
            else        x_if_rd = memf(g_addr);
        end
        chk("mem_en",    mem_en[0],    in_acc);
        chk("mem_we",    mem_we[0],    in_acc && g_we);
        chk("busy",      busy[0],      in_acc || in_resp);
        chk("if_ack",    if_ack[0],    x_if_ack);
        chk("d_ack",     d_ack[0],     x_d_ack);
        chk("owner",     owner[0],     x_owner);
        chk("mem_addr",  mem_addr[0],  x_maddr);
        chk("mem_wdata", mem_wdata[0], x_mwdata);
        chk("if_rdata",  if_rdata[0],  x_if_rd);
        chk("d_rdata",   d_rdata[0],   x_d_rd);
    endtask

    task automatic step();
        @(posedge clk);
        e++;
        model_edge();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic wait_any(output bit port, output int at);
        int n = 0;
        port = 0; at = 0;
        do begin
            step();
            n++;
        end while (!(x_if_ack || x_d_ack) && n < 40);
        if (n >= 40) chk("ack_timeout", 1, 0);
        port = x_d_ack; at = e;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_en"}, mem_en[0], 0);      chk({tag, "_we"}, mem_we[0], 0);
        chk({tag, "_busy"}, busy[0], 0);      chk({tag, "_own"}, owner[0], 0);
        chk({tag, "_iack"}, if_ack[0], 0);    chk({tag, "_dack"}, d_ack[0], 0);
        chk({tag, "_addr"}, mem_addr[0], 0);  chk({tag, "_wd"}, mem_wdata[0], 0);
        chk({tag, "_ird"}, if_rdata[0], 0);   chk({tag, "_drd"}, d_rdata[0], 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic drive_rand();
        if (if_req) begin
            if (x_if_ack) begin
                if ($urandom_range(1) == 1) if_addr = $urandom;
                else                        if_req = 1'b0;
            end else if ($urandom_range(15) == 0) if_req = 1'b0;
        end else begin
            if_addr = $urandom;
            if ($urandom_range(2) == 0) if_req = 1'b1;
        end
        if (d_req) begin
            if (x_d_ack) begin
                if ($urandom_range(1) == 1) begin
                    d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(1));
                end else d_req = 1'b0;
            end else if ($urandom_range(15) == 0) d_req = 1'b0;
        end else begin
            d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(1));
            if ($urandom_range(2) == 0) d_req = 1'b1;
        end
    endtask

    initial begin
        bit          p;
        int          at, prev_at, cnt15;
        bit          exp_p[3];
        logic [31:0] keep;

        reset = 1'b1; if_req = 0; d_req = 0; d_we = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        #1 check_zero("rst");
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Single fetch
        if_addr = 32'h40; if_req = 1'b1;
        wait_any(p, at);
        chk("t1_port", p, 0);
        chk("t1_rdata", if_rdata[0], memf(32'h40));
        if_req = 1'b0;

        // Load then store: the store must leave d_rdata untouched
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        wait_any(p, at);
        d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h1234;
        keep = memf(32'h200);
        wait_any(p, at);
        chk("t2_port", p, 1);
        chk("t2_drd_kept", d_rdata[0], keep);
        d_req = 1'b0; d_we = 1'b0;

        // Tie handling
`ifdef ARB_ROUND_ROBIN_EN
        exp_p = '{0, 1, 0};
`else
        exp_p = '{1, 1, 0};
`endif
        if_addr = 32'h10; d_addr = 32'h20; if_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_any(p, at);
            chk("t3_grant", p, exp_p[k]);
            if_addr = if_addr + 4; d_addr = d_addr + 4;
            if (k == 1) d_req = 1'b0;
        end
        if_req = 1'b0;
        repeat (2) step();

        // Back-to-back fetches spaced by latency + 2
        if_addr = 32'h0; if_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_any(p, at);
            chk("t4_port", p, 0);
            if (k > 0) chk("t4_spacing", at - prev_at, ML + 2);
            prev_at = at;
            if_addr = if_addr + 4;
        end
        if_req = 1'b0;
        repeat (2) step();

        // Reset in the middle of a load
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        step();
        #2 reset = 1'b1;
        #1 check_zero("t5");
        d_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        if_addr = 32'h80; if_req = 1'b1;
        wait_any(p, at);
        chk("t5_first", p, 0);
        if_req = 1'b0;

        // Latency 1 and 15 on a single load; request drops before the ack
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5C0;
        step();
        d_req = 1'b0;
        cnt15 = 0;
        for (int k = 0; k < 18; k++) begin
            if (k > 0) step();
            chk("l1_en", mem_en[1], k < 1);
            chk("l1_ack", d_ack[1], k == 1);
            chk("l15_en", mem_en[2], k < 15);
            chk("l15_ack", d_ack[2], k == 15);
            cnt15 += int'(mem_en[2]);
        end
        chk("l15_en_cnt", cnt15, 15);
        chk("l1_rdata", d_rdata[1], memf(32'h5C0));
        chk("l15_rdata", d_rdata[2], memf(32'h5C0));

        // Random traffic
        do_reset();
        for (int k = 0; k < 600; k++) begin
            step();
            drive_rand();
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (8) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between two requesters.
- The instruction-fetch port is driven during the IF state. The data port is driven during the MEM state by loads and stores, and later by a debug/DMA master.
- The block arbitrates between the two ports, sequences a fixed-latency memory access, and returns read data with a one-cycle acknowledge pulse.
- It sits between the multicycle control FSM/datapath and the memory.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- MEM_LATENCY, 2, number of cycles mem_en is held per access; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- if_req  input  1  instruction-fetch request; held high until if_ack.
- if_addr  input  AW  fetch address; stable while if_req is high.
- if_ack  output  1  one-cycle pulse: fetch complete, if_rdata valid.
- if_rdata  output  DW  registered fetch data; holds its value until the next fetch.
- d_req  input  1  data request; held high until d_ack.
- d_we  input  1  1 = store, 0 = load; stable while d_req is high.
- d_addr  input  AW  data address.
- d_wdata  input  DW  store data.
- d_ack  output  1  one-cycle pulse: data access complete.
- d_rdata  output  DW  registered load data; unchanged by stores.
- mem_en  output  1  memory access enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address (registered).
- mem_wdata  output  DW  memory write data (registered).
- mem_rdata  input  DW  memory read data; valid in the last mem_en cycle.
- busy  output  1  high in the ACCESS and RESP states.
- owner  output  1  current or last grant: 0 = instruction port, 1 = data port.

Behaviour:
Reset values:
- All outputs are 0 and the state is IDLE.
- Round-robin pointer = 1 (data port was last), so instruction is preferred first.
- Reset takes effect immediately, mid-access included: mem_en and mem_we drop asynchronously, no ack is issued, and the aborted access is lost.

States: IDLE, ACCESS, RESP.

IDLE:
- Requests are sampled on each rising edge.
- Only one request high: grant that port.
- Both high: grant the data port (fixed priority; see the optional feature).
- On grant, latch into mem_addr/mem_wdata/mem_we: address, write data and we (instruction port: we = 0, wdata = 0).
- Set mem_en = 1, load the counter with MEM_LATENCY-1, update owner, and go to ACCESS.
- No request: stay in IDLE with mem_en = 0.

ACCESS:
- mem_en is held high and the address, write data and we are held stable.
- The counter decrements each cycle.
- On the edge where the counter = 0:
  - Load: capture mem_rdata into the owner's rdata register.
  - Both: clear mem_en and mem_we, assert the owner's ack, go to RESP.

RESP:
- The ack is high for exactly this cycle; then go to IDLE.
- Requests are not sampled in RESP.

Timing:
- Request first seen high at edge 0 → mem_en high for cycles 1..MEM_LATENCY → ack in cycle MEM_LATENCY+1.
- Back-to-back throughput is one access per MEM_LATENCY+2 cycles.

Protocol rules:
- A requester may keep req high after its ack to issue a new request (new address), sampled in the next IDLE.
- A req that drops before its ack does not abort the access; the access completes and its ack is still pulsed.
- Only one ack is ever high in a cycle; if_ack and d_ack are never high together.
- A store never modifies d_rdata or if_rdata.
- Inputs that change during ACCESS are ignored, because the access uses the latched values.

Optional Feature:
Macro: ARB_ROUND_ROBIN_EN
- Defined: on simultaneous requests in IDLE, grant the port not granted last, using the pointer updated at every grant. A single requester is always granted regardless of the pointer.
- Undefined: the data port always wins a tie. The pointer logic is absent; owner still reports the last grant.

Test Plan:
1. Single fetch, MEM_LATENCY = 2: if_req = 1, if_addr = 0x40, mem_rdata = 0xDEADBEEF → mem_en and mem_addr = 0x40 in cycles 1-2, if_ack in cycle 3 only, if_rdata = 0xDEADBEEF, d_ack stays 0.
2. Store: d_req = 1, d_we = 1, d_addr = 0x100, d_wdata = 0x1234 → mem_we = mem_en = 1 for 2 cycles with mem_wdata = 0x1234; d_ack pulses once; d_rdata keeps its prior value.
3. Tie: if_req and d_req high together for two accesses.
   - Macro undefined: grants are data, then data again if d_req is re-held, with fetch starved until d_req drops.
   - Macro defined: grants alternate instruction, then data.
4. Back-to-back: if_req held high across 3 fetches with addresses 0x0/0x4/0x8 → 3 if_ack pulses spaced exactly 4 cycles apart, mem_addr updates only in IDLE→ACCESS.
5. Reset mid-ACCESS: assert reset during cycle 1 of a load → mem_en drops in the same cycle without waiting for a clock; no d_ack; all outputs are 0; after release, a new if_req is granted first.
6. MEM_LATENCY = 1 and MEM_LATENCY = 15: a single load → mem_en is high for exactly 1 or 15 cycles, ack at cycle 2 or 16, and the captured data is correct.
